// File: rtl/scene_recovery_pkg.sv
// Shared widths and per-channel helpers for the scene-radiance recovery block.
// Channel 0 is blue (bits 7:0), channel 2 is red (bits 23:16).
package scene_recovery_pkg;

    localparam int PIX_W   = 24;
    localparam int CH_W    = 8;
    localparam int RECIP_W = 16;
    localparam int PROD_W  = 26;
    localparam int N_CH    = 3;

    localparam logic signed [PROD_W-1:0] CH_MAX = 255;

    function automatic logic [CH_W-1:0] ch_slice(
        input logic [PIX_W-1:0] pix,
        input int               idx
    );
        return pix[idx*CH_W +: CH_W];
    endfunction

    function automatic logic [CH_W-1:0] clamp_ch(
        input logic signed [PROD_W-1:0] v
    );
        if (v < 0) begin
            return '0;
        end else if (v > CH_MAX) begin
            return '1;
        end else begin
            return v[CH_W-1:0];
        end
    endfunction

endpackage

// File: rtl/scene_recovery_recip_lut.sv
// Registered reciprocal ROM: recip = floor(65536 / max(t, T_MIN)).
// Every entry fits in 16 bits because T_MIN is at least 2.
module recip_lut
    import scene_recovery_pkg::*;
#(
    parameter int T_MIN = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         addr,
    output logic [RECIP_W-1:0] recip
);

    logic [7:0]         tc;
    logic [RECIP_W-1:0] recip_d;
    logic [RECIP_W-1:0] recip_q;

    always_comb begin
        tc      = (addr < 8'(T_MIN)) ? 8'(T_MIN) : addr;
        recip_d = RECIP_W'(32'd65536 / {24'd0, tc});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            recip_q <= '0;
        end else begin
            recip_q <= recip_d;
        end
    end

    assign recip = recip_q;

endmodule

// File: rtl/scene_recovery.sv
// Buffers raw pixels until their transmission arrives, then recovers
// J = (I - A) / max(t, T_MIN) + A per channel through a 3-stage pipeline.
module scene_recovery
    import scene_recovery_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 1024,
    parameter int         T_MIN       = 26,
    parameter logic [7:0] ATM_DEFAULT = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] input_pixel,
    input  logic             input_is_valid,
    input  logic [7:0]       transmission,
    input  logic             trans_valid,
    input  logic [CH_W-1:0]  a_r,
    input  logic [CH_W-1:0]  a_g,
    input  logic [CH_W-1:0]  a_b,
    input  logic             atm_valid,
    output logic [PIX_W-1:0] output_pixel,
    output logic             output_is_valid,
    output logic             fifo_overflow,
    output logic             fifo_underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [PIX_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             empty, full, do_push, do_pop;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic [PIX_W-1:0] rd_pix;

    logic [N_CH-1:0][CH_W-1:0]   atm_q, atm_d;
    logic [N_CH-1:0][CH_W-1:0]   i1_q, i1_d;
    logic [N_CH-1:0][CH_W-1:0]   a1_q, a2_q;
    logic [N_CH-1:0][PROD_W-1:0] p_q, p_d;
    logic [N_CH-1:0][CH_W-1:0]   out_q, out_d;
    logic                        v1_q, v2_q, v3_q;
    logic [RECIP_W-1:0]          recip;

    logic signed [CH_W:0]     d9 [N_CH];
    logic signed [PROD_W-1:0] dx [N_CH];
    logic signed [PROD_W-1:0] qv [N_CH];
    logic signed [PROD_W-1:0] jv [N_CH];
    logic        [PROD_W-1:0] rx;

    recip_lut #(
        .T_MIN(T_MIN)
    ) u_recip_lut (
        .clk  (clk),
        .rst  (rst),
        .addr (transmission),
        .recip(recip)
    );

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW])
             && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        // a pop in the same cycle frees the slot for a push into a full FIFO
        do_pop   = trans_valid && !empty;
        do_push  = input_is_valid && (!full || trans_valid);
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        ovf_d    = ovf_q | (input_is_valid & full & ~trans_valid);
        unf_d    = unf_q | (trans_valid & empty);
        atm_d    = atm_valid ? {a_r, a_g, a_b} : atm_q;
        rd_pix   = do_pop ? mem_q[rd_ptr_q[AW-1:0]] : '0;
        rx       = {{(PROD_W-RECIP_W){1'b0}}, recip};
        for (int c = 0; c < N_CH; c++) begin
            i1_d[c] = ch_slice(rd_pix, c);
            d9[c]   = $signed({1'b0, i1_q[c]}) - $signed({1'b0, a1_q[c]});
            dx[c]   = {{(PROD_W-CH_W-1){d9[c][CH_W]}}, d9[c]};
            p_d[c]  = dx[c] * $signed(rx);
            qv[c]   = $signed(p_q[c]) >>> 8;
            jv[c]   = qv[c] + $signed({{(PROD_W-CH_W){1'b0}}, a2_q[c]});
            out_d[c] = v2_q ? clamp_ch(jv[c]) : out_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= input_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            atm_q    <= {N_CH{ATM_DEFAULT}};
            i1_q     <= '0;
            a1_q     <= '0;
            a2_q     <= '0;
            p_q      <= '0;
            out_q    <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            atm_q    <= atm_d;
            i1_q     <= i1_d;
            a1_q     <= atm_q;
            a2_q     <= a1_q;
            p_q      <= p_d;
            out_q    <= out_d;
            v1_q     <= trans_valid;
            v2_q     <= v1_q;
            v3_q     <= v2_q;
        end
    end

    assign output_pixel    = out_q;
    assign output_is_valid = v3_q;
    assign fifo_overflow   = ovf_q;
    assign fifo_underflow  = unf_q;

endmodule

// File: tb/tb_scene_recovery.sv
// Directed bench for scene_recovery: hand-computed radiance values,
// FIFO overflow/underflow flags, latency and asynchronous reset.
module tb_scene_recovery;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] input_pixel = '0;
    logic        input_is_valid = 1'b0;
    logic [7:0]  transmission = '0;
    logic        trans_valid = 1'b0;
    logic [7:0]  a_r = '0, a_g = '0, a_b = '0;
    logic        atm_valid = 1'b0;
    logic [23:0] output_pixel;
    logic        output_is_valid;
    logic        fifo_overflow;
    logic        fifo_underflow;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] outq [$];

    scene_recovery dut (
        .clk            (clk),
        .rst            (rst),
        .input_pixel    (input_pixel),
        .input_is_valid (input_is_valid),
        .transmission   (transmission),
        .trans_valid    (trans_valid),
        .a_r            (a_r),
        .a_g            (a_g),
        .a_b            (a_b),
        .atm_valid      (atm_valid),
        .output_pixel   (output_pixel),
        .output_is_valid(output_is_valid),
        .fifo_overflow  (fifo_overflow),
        .fifo_underflow (fifo_underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (output_is_valid) outq.push_back(output_pixel);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic push, input logic [23:0] pix,
                       input logic pop, input logic [7:0] t);
        input_is_valid = push;
        input_pixel    = pix;
        trans_valid    = pop;
        transmission   = t;
        @(negedge clk);
        input_is_valid = 1'b0;
        trans_valid    = 1'b0;
    endtask

    initial begin
        int bad;
        repeat (2) @(negedge clk);
        chk("rst_pix", output_pixel, 24'h0);
        chk("rst_vld", output_is_valid, 1'b0);
        chk("rst_ovf", fifo_overflow, 1'b0);
        chk("rst_unf", fifo_underflow, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // default A = 255
        cyc(1, 24'hFF8040, 0, 8'd0);
        cyc(0, 24'h0, 1, 8'd255);
        @(negedge clk);
        chk("lat2_vld", output_is_valid, 1'b0);
        @(negedge clk);
        chk("lat3_vld", output_is_valid, 1'b1);
        chk("dflt_A", output_pixel, 24'hFF7F3F);
        @(negedge clk);
        chk("hold_vld", output_is_valid, 1'b0);
        chk("hold_pix", output_pixel, 24'hFF7F3F);

        // A = 200, back-to-back pops
        a_r = 8'd200; a_g = 8'd200; a_b = 8'd200; atm_valid = 1'b1;
        @(negedge clk);
        atm_valid = 1'b0;
        cyc(1, 24'h646464, 0, 8'd0);
        cyc(1, 24'hDCDCDC, 0, 8'd0);
        cyc(1, 24'h646464, 0, 8'd0);
        cyc(1, 24'hDCDCDC, 0, 8'd0);
        outq.delete();
        cyc(0, 24'h0, 1, 8'd255);
        cyc(0, 24'h0, 1, 8'd128);
        cyc(0, 24'h0, 1, 8'd128);
        cyc(0, 24'h0, 1, 8'd10);
        repeat (2) @(negedge clk);
        chk("b2b_cnt", outq.size(), 4);
        if (outq.size() == 4) begin
            chk("t255", outq[0], 24'h636363);
            chk("t128", outq[1], 24'hF0F0F0);
            chk("lo_clamp", outq[2], 24'h000000);
            chk("hi_clamp", outq[3], 24'hFFFFFF);
        end

        // A load in the same cycle as a pop applies to later pops only
        outq.delete();
        cyc(1, 24'h646464, 0, 8'd0);
        a_r = 8'd10; a_g = 8'd10; a_b = 8'd10; atm_valid = 1'b1;
        cyc(0, 24'h0, 1, 8'd255);
        atm_valid = 1'b0;
        cyc(1, 24'h646464, 0, 8'd0);
        cyc(0, 24'h0, 1, 8'd128);
        repeat (3) @(negedge clk);
        chk("atm_cnt", outq.size(), 2);
        if (outq.size() == 2) begin
            chk("atm_old", outq[0], 24'h636363);
            chk("atm_new", outq[1], 24'hBEBEBE);
        end

        // underflow, push+pop on empty is not bypassed
        chk("pre_unf", fifo_underflow, 1'b0);
        outq.delete();
        cyc(1, 24'h141414, 1, 8'd128);
        cyc(0, 24'h0, 1, 8'd128);
        repeat (3) @(negedge clk);
        chk("unf_flag", fifo_underflow, 1'b1);
        chk("unf_ovf", fifo_overflow, 1'b0);
        chk("unf_cnt", outq.size(), 2);
        if (outq.size() == 2) begin
            chk("unf_pix", outq[0], 24'h000000);
            chk("nobypass", outq[1], 24'h1E1E1E);
        end

        // overflow after reset, A back to default
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_unf", fifo_underflow, 1'b0);
        for (int k = 0; k < 1025; k++) begin
            cyc(1, (k == 1024) ? 24'h000000 : 24'hFF8040, 0, 8'd0);
        end
        chk("ovf_flag", fifo_overflow, 1'b1);
        outq.delete();
        cyc(1, 24'hFFFFFF, 1, 8'd255);
        chk("ovf_stky", fifo_overflow, 1'b1);
        for (int k = 0; k < 1024; k++) begin
            cyc(0, 24'h0, 1, 8'd255);
        end
        repeat (3) @(negedge clk);
        chk("drain_cnt", outq.size(), 1025);
        bad = 0;
        for (int k = 0; k < 1024 && k < outq.size(); k++) begin
            if (outq[k] !== 24'hFF7F3F) bad++;
        end
        chk("drain_bad", bad, 0);
        if (outq.size() == 1025) chk("full_push", outq[1024], 24'hFFFFFF);
        chk("drain_unf", fifo_underflow, 1'b0);
        cyc(0, 24'h0, 1, 8'd255);
        chk("empty_unf", fifo_underflow, 1'b1);

        // asynchronous reset mid-burst
        repeat (4) @(negedge clk);
        for (int k = 0; k < 5; k++) cyc(1, 24'hFF8040, 0, 8'd0);
        trans_valid  = 1'b1;
        transmission = 8'd255;
        repeat (3) @(negedge clk);
        chk("burst_vld", output_is_valid, 1'b1);
        chk("burst_pix", output_pixel, 24'hFF7F3F);
        #2 rst = 1'b0;
        #1;
        chk("arst_pix", output_pixel, 24'h0);
        chk("arst_vld", output_is_valid, 1'b0);
        chk("arst_ovf", fifo_overflow, 1'b0);
        @(negedge clk);
        trans_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("arst_unf", fifo_underflow, 1'b0);
        cyc(0, 24'h0, 1, 8'd255);
        repeat (2) @(negedge clk);
        chk("post_vld", output_is_valid, 1'b1);
        chk("post_pix", output_pixel, 24'h000000);
        chk("post_unf", fifo_underflow, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
